fuzz_stim_sequencer: RTL and testbench

Synthesizable stimulus scheduler for the fuzz harness. It replaces the behavioural LCG loop with a clocked controller. It expands a 32-bit seed into full-width random input vectors using the harness LCG (multiplier 0x41C64E6D, increment 0x3039), applies one vector at a time to the DUT's flat input bus, and waits a configurable DUT latency. It then folds the DUT's flat output bus into a running signature, which lets cross-simulator comparisons check a single word instead of a per-cycle trace.

---
 rtl/fuzz_stim_sequencer_if.sv | 32 +++
 rtl/fuzz_stim_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fuzz_stim_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fuzz_stim_sequencer_if.sv
// Port bundle between the fuzz harness controller (master) and fuzz_stim_sequencer (slave).
// Exposes the sequencer FSM state on state_dbg so external checkers can follow the run.
interface fuzz_stim_sequencer_if #(
    parameter int IN_W  = 261,
    parameter int OUT_W = 330,
    parameter int CYC_W = 32
);
    // start is a level sampled only while the sequencer is IDLE or DONE (busy low); there is
    // no ready, acceptance is implied by busy rising on the next edge. abort always wins.
    logic             start;
    logic             abort;
    logic [31:0]      seed;
    logic [CYC_W-1:0] cycles;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  dut_in;
    logic             apply;
    logic             busy;
    logic             done;
    logic [CYC_W-1:0] cyc_count;
    logic [31:0]      signature;
    logic [2:0]       state_dbg;

    modport master (
        output start, abort, seed, cycles, dut_out,
        input  dut_in, apply, busy, done, cyc_count, signature, state_dbg
    );

    modport slave (
        input  start, abort, seed, cycles, dut_out,
        output dut_in, apply, busy, done, cyc_count, signature, state_dbg
    );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// Clocked LCG stimulus scheduler: fills a vector word by word, applies it atomically, waits LAT,
// folds dut_out into a signature. Optional signature logic: define FUZZ_SEQ_SIGNATURE_EN.
module fuzz_stim_sequencer #(
    parameter int IN_W  = 261,
    parameter int OUT_W = 330,
    parameter int CYC_W = 32,
    parameter int LAT   = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    fuzz_stim_sequencer_if.slave bus
);
    localparam int W   = (IN_W + 31) / 32;
    localparam int K_W = (W > 1) ? $clog2(W) : 1;
    localparam int L_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_APPLY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      rng_q, rng_d, rng_step;
    logic [IN_W-1:0]  shadow_q, shadow_d, dut_in_q, dut_in_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [L_W-1:0]   lat_q, lat_d;
    logic [CYC_W-1:0] cycles_q, cycles_d, cyc_count_q, cyc_count_d, cyc_next;
    logic             apply_q, apply_d, busy_q, busy_d, done_q, done_d;
    logic [W*32-1:0]  word_mask, word_rep;

    assign rng_step  = rng_q * LCG_MUL + LCG_INC;
    assign cyc_next  = cyc_count_q + CYC_W'(1);
    // Word k of the shadow is replaced in one go; the cast drops the truncated top of the last word.
    assign word_mask = (W*32)'(32'hFFFF_FFFF) << {k_q, 5'b0};
    assign word_rep  = {W{rng_step}};

`ifdef FUZZ_SEQ_SIGNATURE_EN
    localparam int C = (OUT_W + 31) / 32;
    logic [31:0]     sig_q, sig_d, fold;
    logic [C*32-1:0] out_pad;

    always_comb begin
        out_pad = (C*32)'(bus.dut_out);
        fold    = '0;
        for (int i = 0; i < C; i++) begin
            fold = fold ^ 32'(out_pad >> (i * 32));
        end
    end

    assign bus.signature = sig_q;
`else
    assign bus.signature = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rng_d       = rng_q;
        shadow_d    = shadow_q;
        dut_in_d    = dut_in_q;
        k_d         = k_q;
        lat_d       = lat_q;
        cycles_d    = cycles_q;
        cyc_count_d = cyc_count_q;
        apply_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
`ifdef FUZZ_SEQ_SIGNATURE_EN
        sig_d       = sig_q;
`endif
        if (bus.abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                    if (bus.start) begin
                        rng_d       = bus.seed;
                        cycles_d    = bus.cycles;
                        cyc_count_d = '0;
                        done_d      = 1'b0;
                        busy_d      = 1'b1;
                        k_d         = '0;
`ifdef FUZZ_SEQ_SIGNATURE_EN
                        sig_d       = '0;
`endif
                        state_d     = (bus.cycles == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    rng_d    = rng_step;
                    shadow_d = IN_W'(((W*32)'(shadow_q) & ~word_mask) | (word_rep & word_mask));
                    if (k_q == K_W'(W - 1)) begin
                        k_d     = '0;
                        state_d = S_APPLY;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
                S_APPLY: begin
                    dut_in_d = shadow_q;
                    apply_d  = 1'b1;
                    lat_d    = '0;
                    state_d  = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (lat_q == L_W'(LAT)) begin
                        cyc_count_d = cyc_next;
`ifdef FUZZ_SEQ_SIGNATURE_EN
                        sig_d       = {sig_q[30:0], sig_q[31]} ^ fold;
`endif
                        state_d     = (cyc_next == cycles_q) ? S_DONE : S_FILL;
                    end else begin
                        lat_d = lat_q + L_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rng_q       <= '0;
            shadow_q    <= '0;
            dut_in_q    <= '0;
            k_q         <= '0;
            lat_q       <= '0;
            cycles_q    <= '0;
            cyc_count_q <= '0;
            apply_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FUZZ_SEQ_SIGNATURE_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rng_q       <= rng_d;
            shadow_q    <= shadow_d;
            dut_in_q    <= dut_in_d;
            k_q         <= k_d;
            lat_q       <= lat_d;
            cycles_q    <= cycles_d;
            cyc_count_q <= cyc_count_d;
            apply_q     <= apply_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FUZZ_SEQ_SIGNATURE_EN
            sig_q       <= sig_d;
`endif
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.apply     = apply_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cyc_count = cyc_count_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed bench for fuzz_stim_sequencer: one instance with LAT=0, one with LAT=2.
// Expected vectors come from a local LCG model; signatures are hand-computed constants.
module tb_fuzz_stim_sequencer;
  localparam int IN_W  = 261;
  localparam int OUT_W = 330;
  localparam int CYC_W = 32;
  localparam int W     = 9;

`ifdef FUZZ_SEQ_SIGNATURE_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fuzz_stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CYC_W(CYC_W)) bus0 ();
  fuzz_stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CYC_W(CYC_W)) bus2 ();

  fuzz_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CYC_W(CYC_W), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  fuzz_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .CYC_W(CYC_W), .LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [IN_W-1:0] last_vec;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  // Produces the next vector from LCG state r_in; word k fills bits [32k+31:32k].
  task automatic model_vec(input logic [31:0] r_in, output logic [31:0] r_out,
                           output logic [IN_W-1:0] v);
    logic [W*32-1:0] wide;
    logic [31:0] r;
    r = r_in;
    wide = '0;
    for (int k = 0; k < W; k++) begin
      r = lcg(r);
      wide[k*32 +: 32] = r;
    end
    v = wide[IN_W-1:0];
    r_out = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.start = 0; bus0.abort = 0; bus0.seed = '0; bus0.cycles = '0; bus0.dut_out = '0;
    bus2.start = 0; bus2.abort = 0; bus2.seed = '0; bus2.cycles = '0; bus2.dut_out = '0;
    tick(); tick();
    n_checks++; if (bus0.dut_in !== '0) begin n_fail++; $display("FAIL reset_dut_in: got %h expected 0", bus0.dut_in); end
    n_checks++; if (bus0.apply !== 1'b0) begin n_fail++; $display("FAIL reset_apply: got %b expected 0", bus0.apply); end
    n_checks++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", bus0.busy, bus0.done); end
    n_checks++; if (bus0.cyc_count !== '0) begin n_fail++; $display("FAIL reset_cyc_count: got %h expected 0", bus0.cyc_count); end
    n_checks++; if (bus0.signature !== 32'h0) begin n_fail++; $display("FAIL reset_signature: got %h expected 0", bus0.signature); end
    n_checks++; if (bus0.state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus0.state_dbg); end
    n_checks++; if (bus2.busy !== 1'b0 || bus2.dut_in !== '0) begin n_fail++; $display("FAIL reset_dut2: got busy %b dut_in %h expected 0", bus2.busy, bus2.dut_in); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_vector();
    logic [31:0] r;
    logic [IN_W-1:0] v;
    bus0.seed = 32'h0; bus0.cycles = 1; bus0.start = 1;
    tick();
    bus0.start = 0;
    model_vec(32'h0, r, v);
    repeat (9) tick();
    n_checks++; if (bus0.apply !== 1'b0) begin n_fail++; $display("FAIL single_apply_c9: got %b expected 0", bus0.apply); end
    tick();
    n_checks++; if (bus0.dut_in[31:0] !== 32'h0000_3039) begin n_fail++; $display("FAIL single_word0: got %h expected 00003039", bus0.dut_in[31:0]); end
    n_checks++; if (bus0.dut_in !== v) begin n_fail++; $display("FAIL single_vector: got %h expected %h", bus0.dut_in, v); end
    n_checks++; if (bus0.apply !== 1'b1) begin n_fail++; $display("FAIL single_apply_c10: got %b expected 1", bus0.apply); end
    tick();
    n_checks++; if (bus0.apply !== 1'b0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL single_c11: got apply %b done %b expected 0 0", bus0.apply, bus0.done); end
    tick();
    n_checks++; if (bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got done %b busy %b expected 1 0", bus0.done, bus0.busy); end
    n_checks++; if (bus0.cyc_count !== 32'd1) begin n_fail++; $display("FAIL single_cyc_count: got %0d expected 1", bus0.cyc_count); end
  endtask

  task automatic test_signature();
    logic [31:0] r;
    logic [IN_W-1:0] v;
    logic [31:0] exp_sig [3];
    exp_sig[0] = SIG_ON ? 32'h1 : 32'h0;
    exp_sig[1] = SIG_ON ? 32'h3 : 32'h0;
    exp_sig[2] = SIG_ON ? 32'h7 : 32'h0;
    bus0.dut_out = OUT_W'(1);
    bus0.seed = 32'h1; bus0.cycles = 3; bus0.start = 1;
    tick();
    bus0.start = 0;
    r = 32'h1;
    for (int i = 0; i < 3; i++) begin
      repeat (10) tick();
      model_vec(r, r, v);
      if (i == 0) begin
        n_checks++; if (bus0.dut_in[31:0] !== 32'h41C6_7EA6) begin n_fail++; $display("FAIL sig_word0: got %h expected 41c67ea6", bus0.dut_in[31:0]); end
      end
      n_checks++; if (bus0.apply !== 1'b1 || bus0.dut_in !== v) begin n_fail++; $display("FAIL sig_vec%0d: got apply %b %h expected 1 %h", i, bus0.apply, bus0.dut_in, v); end
      tick();
      n_checks++; if (bus0.cyc_count !== 32'(i + 1)) begin n_fail++; $display("FAIL sig_count%0d: got %0d expected %0d", i, bus0.cyc_count, i + 1); end
      n_checks++; if (bus0.signature !== exp_sig[i]) begin n_fail++; $display("FAIL sig_value%0d: got %h expected %h", i, bus0.signature, exp_sig[i]); end
    end
    tick();
    n_checks++; if (bus0.done !== 1'b1 || bus0.signature !== exp_sig[2]) begin n_fail++; $display("FAIL sig_final: got done %b sig %h expected 1 %h", bus0.done, bus0.signature, exp_sig[2]); end
    last_vec = v;
  endtask

  task automatic test_zero_cycles();
    bus0.cycles = 0; bus0.start = 1;
    tick();
    bus0.start = 0;
    n_checks++; if (bus0.state_dbg !== 3'd4) begin n_fail++; $display("FAIL zero_state: got %0d expected 4", bus0.state_dbg); end
    tick();
    n_checks++; if (bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done %b busy %b expected 1 0", bus0.done, bus0.busy); end
    n_checks++; if (bus0.dut_in !== last_vec) begin n_fail++; $display("FAIL zero_dut_in: got %h expected %h", bus0.dut_in, last_vec); end
    n_checks++; if (bus0.cyc_count !== '0) begin n_fail++; $display("FAIL zero_count: got %0d expected 0", bus0.cyc_count); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus0.apply !== 1'b0) begin n_fail++; $display("FAIL zero_apply: got %b expected 0", bus0.apply); end
      tick();
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic [IN_W-1:0] v;
    bus0.seed = 32'h5; bus0.cycles = 3; bus0.start = 1;
    tick();
    bus0.start = 0;
    model_vec(32'h5, r, v);
    repeat (10) tick();
    n_checks++; if (bus0.dut_in !== v) begin n_fail++; $display("FAIL abort_vec1: got %h expected %h", bus0.dut_in, v); end
    tick();
    n_checks++; if (bus0.cyc_count !== 32'd1) begin n_fail++; $display("FAIL abort_count1: got %0d expected 1", bus0.cyc_count); end
    repeat (4) tick();
    n_checks++; if (bus0.state_dbg !== 3'd1) begin n_fail++; $display("FAIL abort_in_fill: got %0d expected 1", bus0.state_dbg); end
    bus0.abort = 1; bus0.start = 1;
    tick();
    bus0.abort = 0; bus0.start = 0;
    n_checks++; if (bus0.state_dbg !== 3'd0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got state %0d busy %b done %b expected 0 0 0", bus0.state_dbg, bus0.busy, bus0.done); end
    n_checks++; if (bus0.dut_in !== v || bus0.cyc_count !== 32'd1) begin n_fail++; $display("FAIL abort_hold: got %h count %0d expected %h 1", bus0.dut_in, bus0.cyc_count, v); end
    n_checks++; if (bus0.signature !== (SIG_ON ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL abort_sig: got %h expected %h", bus0.signature, SIG_ON ? 32'h1 : 32'h0); end
    tick();
    n_checks++; if (bus0.busy !== 1'b0 || bus0.state_dbg !== 3'd0) begin n_fail++; $display("FAIL abort_start_ignored: got busy %b state %0d expected 0 0", bus0.busy, bus0.state_dbg); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    logic [IN_W-1:0] v1, v2;
    model_vec(32'hCAFE_BABE, r, v1);
    model_vec(r, r, v2);
    bus0.seed = 32'hCAFE_BABE; bus0.cycles = 3; bus0.start = 1;
    tick();
    bus0.start = 0;
    repeat (10) tick();
    n_checks++; if (bus0.dut_in !== v1) begin n_fail++; $display("FAIL rmid_v1: got %h expected %h", bus0.dut_in, v1); end
    repeat (11) tick();
    n_checks++; if (bus0.dut_in !== v2 || bus0.apply !== 1'b1) begin n_fail++; $display("FAIL rmid_v2: got %h apply %b expected %h 1", bus0.dut_in, bus0.apply, v2); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus0.dut_in !== '0 || bus0.apply !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got %h apply %b busy %b done %b expected 0", bus0.dut_in, bus0.apply, bus0.busy, bus0.done); end
    n_checks++; if (bus0.cyc_count !== '0 || bus0.signature !== 32'h0 || bus0.state_dbg !== 3'd0) begin n_fail++; $display("FAIL rmid_regs: got count %0d sig %h state %0d expected 0", bus0.cyc_count, bus0.signature, bus0.state_dbg); end
    rst_n = 1'b1;
    bus0.cycles = 2; bus0.start = 1;
    tick();
    bus0.start = 0;
    repeat (10) tick();
    n_checks++; if (bus0.dut_in !== v1) begin n_fail++; $display("FAIL rmid_rerun_v1: got %h expected %h", bus0.dut_in, v1); end
    repeat (11) tick();
    n_checks++; if (bus0.dut_in !== v2) begin n_fail++; $display("FAIL rmid_rerun_v2: got %h expected %h", bus0.dut_in, v2); end
    repeat (2) tick();
    n_checks++; if (bus0.done !== 1'b1 || bus0.cyc_count !== 32'd2) begin n_fail++; $display("FAIL rmid_rerun_done: got done %b count %0d expected 1 2", bus0.done, bus0.cyc_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [IN_W-1:0] v;
    logic [31:0] sig_run [2];
    logic [31:0] exp_sig;
    // All-ones dut_out: ten full chunks cancel, the 10-bit tail folds to 0x3FF.
    exp_sig = SIG_ON ? 32'h0000_1405 : 32'h0;
    bus2.dut_out = '1;
    bus2.seed = 32'h1234_5678; bus2.cycles = 4;
    for (int run = 0; run < 2; run++) begin
      bus2.start = 1;
      tick();
      bus2.start = 0;
      r = 32'h1234_5678;
      repeat (10) tick();
      for (int i = 0; i < 4; i++) begin
        model_vec(r, r, v);
        n_checks++; if (bus2.apply !== 1'b1 || bus2.dut_in !== v) begin n_fail++; $display("FAIL b2b_r%0d_v%0d: got apply %b %h expected 1 %h", run, i, bus2.apply, bus2.dut_in, v); end
        if (i < 3) repeat (13) tick();
      end
      repeat (3) tick();
      n_checks++; if (bus2.done !== 1'b0 || bus2.cyc_count !== 32'd4) begin n_fail++; $display("FAIL b2b_r%0d_c52: got done %b count %0d expected 0 4", run, bus2.done, bus2.cyc_count); end
      tick();
      n_checks++; if (bus2.done !== 1'b1 || bus2.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_r%0d_done: got done %b busy %b expected 1 0", run, bus2.done, bus2.busy); end
      n_checks++; if (bus2.signature !== exp_sig) begin n_fail++; $display("FAIL b2b_r%0d_sig: got %h expected %h", run, bus2.signature, exp_sig); end
      sig_run[run] = bus2.signature;
    end
    n_checks++; if (sig_run[1] !== sig_run[0]) begin n_fail++; $display("FAIL b2b_sig_repeat: got %h expected %h", sig_run[1], sig_run[0]); end
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_signature();
    test_zero_cycles();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
